div_unit: RTL and testbench

Multi-cycle 32-bit integer divider serving the execute stage as the responder for DIV/DIVU. EX is the initiator: it raises a start request with operands and holds it until the divider reports completion. EX then writes the packed result into HI/LO through its existing whilo path: remainder to HI, quotient to LO. Radix-2 restoring division, one quotient bit per cycle, with a separate fast path for a zero divisor.

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Result packs {remainder, quotient}; a zero divisor completes in two cycles with a zero result.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] partial_q, partial_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] mag1, mag2;
    logic [32:0] diff;
    logic [31:0] quot_mag, rem_mag;
    logic [31:0] quot_fin, rem_fin;

    always_comb begin
        mag1     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag2     = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        diff     = partial_q[64:32] - {1'b0, divisor_q};
        quot_mag = partial_q[31:0];
        rem_mag  = partial_q[64:33];
        // 0x80000000 / -1 wraps naturally here: negating 0x80000000 yields itself.
        quot_fin = neg_quot_q ? (~quot_mag + 32'd1) : quot_mag;
        rem_fin  = neg_rem_q  ? (~rem_mag + 32'd1)  : rem_mag;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        partial_d  = partial_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            ST_FREE: begin
                ready_d  = 1'b0;
                result_d = 64'd0;
                cnt_d    = 6'd0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        state_d    = ST_ON;
                        partial_d  = {32'd0, mag1, 1'b0};
                        divisor_d  = mag2;
                        neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d  = signed_div_i && opdata1_i[31];
                    end
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                    cnt_d    = 6'd0;
                end else begin
                    state_d  = ST_END;
                    ready_d  = 1'b1;
                    result_d = 64'd0;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                    cnt_d    = 6'd0;
                end else if (cnt_q != 6'd32) begin
                    // Trial subtraction: keep the difference only when it did not borrow.
                    if (diff[32]) begin
                        partial_d = {partial_q[63:0], 1'b0};
                    end else begin
                        partial_d = {diff[31:0], partial_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = ST_END;
                    ready_d  = 1'b1;
                    result_d = {rem_fin, quot_fin};
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FREE;
            cnt_q      <= 6'd0;
            partial_q  <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            partial_q  <= partial_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, annul/reset interruptions and random
// divisions checked against an arithmetic reference model through an expected queue.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, zero divisor gives 0, signed overflow wraps.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one division, scramble operands after acceptance, wait for ready,
    // check latency/result, check hold while start stays high and clear after drop.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int exp_lat;
        logic [63:0] exp;
        exp_q.push_back(ref_div(sgn, a, b));
        exp_lat = (b == 32'd0) ? 2 : 34;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        exp = exp_q.pop_front();
        check({tag, "_result"}, result_o, exp);
        for (int i = 0; i < 2; i++) tick();
        check({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        start_i = 1'b0;
        tick();
        check({tag, "_clear"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    // Start a nonzero division and interrupt it with annul or reset before edge n.
    task automatic interrupt(input string tag, input logic use_rst, input int n);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int i = 1; i < n; i++) tick();
        if (use_rst) rst = 1'b1;
        else annul_i = 1'b1;
        tick();
        check({tag, "_after"}, {result_o[62:0], ready_o}, 64'd0);
        rst     = 1'b0;
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        check({tag, "_idle"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        tick();

        do_div("u100_7", 1'b0, 32'd100, 32'd7);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_div("u5_0", 1'b0, 32'd5, 32'd0);
        do_div("s5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_div("u_small_big", 1'b0, 32'd3, 32'h8000_0001);

        interrupt("annul_e10", 1'b0, 10);
        do_div("u9_3", 1'b0, 32'd9, 32'd3);
        interrupt("rst_e20", 1'b1, 20);
        do_div("u100_7_again", 1'b0, 32'd100, 32'd7);

        for (int k = 0; k < 20; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = ~b + 32'd1;
                default: ;
            endcase
            do_div("rand", 1'($urandom_range(0, 1)), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
